regfile_write_sequencer: RTL and testbench

//  Owns the single write port of the decode-stage register file and its rm[0:1] exception registers.
//  Two requesters share the port:
//   - the MEM/WB writeback path (one GPR write per instruction);
//   - the exception path, which saves PC into rm[0] and faulty address into rm[1] over two cycles.
//  A Moore FSM sequences the exception save and stalls writeback while the save runs.
//  It also keeps a saturating count of exceptions taken.

---
 rtl/regfile_write_sequencer.sv | 126 ++++++++++++
 tb/tb_regfile_write_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// rtl/regfile_write_sequencer.sv - write-port sequencer for GPR writeback and rm[0:1] exception save
//
// Purpose: arbitrates the single register-file write port between the MEM/WB
// writeback path and the exception-save sequence (PC -> rm[0], faulty address
// -> rm[1]), stalls writeback while a save runs, and counts exceptions taken.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   wb_valid, wb_rd, wb_data       writeback request
//   wb_ready                       writeback accepted this cycle (0 = stall)
//   exc_req, exc_pc, exc_addr      exception save request (level) and payload
//   exc_ack                        one-cycle pulse after both rm writes
//   rf_we, rf_waddr, rf_wdata      registered GPR write port
//   rm_we, rm_sel, rm_wdata        rm write port (sel 0 = PC, 1 = address)
//   busy                           save sequence in progress
//   exc_count                      saturating count of accepted exceptions
module regfile_write_sequencer #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int CNT_W          = 8,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              exc_req,
  input  logic [DATA_W-1:0] exc_pc,
  input  logic [DATA_W-1:0] exc_addr,
  output logic              exc_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rm_we,
  output logic              rm_sel,
  output logic [DATA_W-1:0] rm_wdata,
  output logic              busy,
  output logic [CNT_W-1:0]  exc_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SAVE_PC   = 2'd1;
  localparam logic [1:0] SAVE_ADDR = 2'd2;
  localparam logic [1:0] ACK       = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] hold_pc;
  logic [DATA_W-1:0] hold_addr;
  logic              wb_accept;
  logic              exc_accept;
  logic              zero_dst;

  // Gated by rst_n so the handshake reads 0 while reset is held.
  assign wb_ready   = (state == IDLE) && rst_n;
  assign busy       = (state != IDLE);
  assign wb_accept  = wb_valid && wb_ready;
  assign exc_accept = (state == IDLE) && exc_req;
  assign zero_dst   = ZERO_HARDWIRED && (wb_rd == '0);

  // exc_req is only looked at in IDLE; the save runs to completion regardless.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (exc_req) state_nxt = SAVE_PC;
      SAVE_PC:   state_nxt = SAVE_ADDR;
      SAVE_ADDR: state_nxt = ACK;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rm_we    = 1'b0;
    rm_sel   = 1'b0;
    rm_wdata = '0;
    exc_ack  = 1'b0;
    case (state)
      SAVE_PC: begin
        rm_we    = 1'b1;
        rm_wdata = hold_pc;
      end
      SAVE_ADDR: begin
        rm_we    = 1'b1;
        rm_sel   = 1'b1;
        rm_wdata = hold_addr;
      end
      ACK:     exc_ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_pc   <= '0;
      hold_addr <= '0;
      exc_count <= '0;
    end else begin
      state <= state_nxt;
      if (exc_accept) begin
        hold_pc   <= exc_pc;
        hold_addr <= exc_addr;
        if (exc_count != '1) exc_count <= exc_count + 1'b1;
      end
    end
  end

  // Writeback may be accepted in the same cycle an exception is taken: the
  // GPR write belongs to the older instruction and lands alongside rm[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb_accept && !zero_dst;
      if (wb_accept) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// tb/tb_regfile_write_sequencer.sv - directed table-driven bench for regfile_write_sequencer
module tb_regfile_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        exc_req;
  logic [31:0] exc_pc, exc_addr;
  logic        exc_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rm_we, rm_sel;
  logic [31:0] rm_wdata;
  logic        busy;
  logic [7:0]  exc_count;

  logic        exc_req2;
  logic        wb_ready2, exc_ack2, rf_we2, rm_we2, rm_sel2, busy2;
  logic [4:0]  rf_waddr2;
  logic [31:0] rf_wdata2, rm_wdata2;
  logic [1:0]  exc_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_write_sequencer u_dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .exc_req(exc_req), .exc_pc(exc_pc), .exc_addr(exc_addr), .exc_ack(exc_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rm_we(rm_we), .rm_sel(rm_sel), .rm_wdata(rm_wdata),
    .busy(busy), .exc_count(exc_count)
  );

  regfile_write_sequencer #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(1'b0), .wb_rd(5'd0), .wb_data(32'd0), .wb_ready(wb_ready2),
    .exc_req(exc_req2), .exc_pc(32'h0000_0100), .exc_addr(32'h0000_0200), .exc_ack(exc_ack2),
    .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
    .rm_we(rm_we2), .rm_sel(rm_sel2), .rm_wdata(rm_wdata2),
    .busy(busy2), .exc_count(exc_count2)
  );

  typedef struct {
    logic        wv;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        er;
    logic [31:0] pc;
    logic [31:0] ad;
    logic        e_rf_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_rm_we;
    logic        e_rm_sel;
    logic [31:0] e_rm_wdata;
    logic        e_ack;
    logic        e_ready;
    logic        e_busy;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp6 [5];
    exp6[0] = 2'd1; exp6[1] = 2'd2; exp6[2] = 2'd3; exp6[3] = 2'd3; exp6[4] = 2'd3;

    //          wv   rd  wd            er   pc            ad             rfwe wa  wdata        rmwe sel rmdata        ack rdy busy cnt
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 5'd0, 32'h55,       1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 32'h400,      32'h1234,     1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h400,   1'b0, 1'b0, 1'b1, 8'd1};
    vecs[4]  = '{1'b1, 5'd7, 32'h99,       1'b1, 32'hBAD,      32'hBAD,      1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h1234,  1'b0, 1'b0, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 32'h400,      32'h1234,     1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 8'd1};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 5'd3, 32'h77,       1'b1, 32'h800,      32'h2000,     1'b1, 5'd3, 32'h77,       1'b1, 1'b0, 32'h800,   1'b0, 1'b0, 1'b1, 8'd2};
    vecs[8]  = '{1'b1, 5'd3, 32'h77,       1'b1, 32'h800,      32'h2000,     1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'h2000,  1'b0, 1'b0, 1'b1, 8'd2};
    vecs[9]  = '{1'b1, 5'd3, 32'h77,       1'b1, 32'h800,      32'h2000,     1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 5'd3, 32'h77,       1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 8'd2};
    vecs[11] = '{1'b1, 5'd3, 32'h77,       1'b0, 32'h0,        32'h0,        1'b1, 5'd3, 32'h77,       1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 8'd2};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 8'd2};

    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    exc_req  = 1'b0;
    exc_pc   = '0;
    exc_addr = '0;
    exc_req2 = 1'b0;

    #12;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rm_we", {31'd0, rm_we}, 32'd0);
    chk("rst_ack", {31'd0, exc_ack}, 32'd0);
    chk("rst_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {24'd0, exc_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, wb_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      wb_valid = vecs[i].wv;
      wb_rd    = vecs[i].rd;
      wb_data  = vecs[i].wd;
      exc_req  = vecs[i].er;
      exc_pc   = vecs[i].pc;
      exc_addr = vecs[i].ad;
      step();
      chk($sformatf("v%0d_rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].e_rf_we});
      if (vecs[i].e_rf_we) begin
        chk($sformatf("v%0d_rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].e_waddr});
        chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wdata);
      end
      chk($sformatf("v%0d_rm_we", i), {31'd0, rm_we}, {31'd0, vecs[i].e_rm_we});
      if (vecs[i].e_rm_we) begin
        chk($sformatf("v%0d_rm_sel", i), {31'd0, rm_sel}, {31'd0, vecs[i].e_rm_sel});
        chk($sformatf("v%0d_rm_wdata", i), rm_wdata, vecs[i].e_rm_wdata);
      end
      chk($sformatf("v%0d_ack", i), {31'd0, exc_ack}, {31'd0, vecs[i].e_ack});
      chk($sformatf("v%0d_ready", i), {31'd0, wb_ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_cnt", i), {24'd0, exc_count}, {24'd0, vecs[i].e_cnt});
    end

    // Async reset in the middle of a save: the save is abandoned with no ack.
    wb_valid = 1'b0;
    exc_req  = 1'b1;
    exc_pc   = 32'h10;
    exc_addr = 32'h20;
    step();
    exc_pc   = 32'h0;
    exc_addr = 32'h0;
    step();
    chk("mid_save_sel", {31'd0, rm_sel}, 32'd1);
    chk("mid_save_data", rm_wdata, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rm_we", {31'd0, rm_we}, 32'd0);
    chk("arst_rm_wdata", rm_wdata, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, wb_ready}, 32'd0);
    chk("arst_cnt", {24'd0, exc_count}, 32'd0);
    exc_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("arst_noack%0d", k), {31'd0, exc_ack}, 32'd0);
      chk($sformatf("arst_idle%0d", k), {31'd0, wb_ready}, 32'd1);
      chk($sformatf("arst_cnt%0d", k), {24'd0, exc_count}, 32'd0);
    end

    // Saturation with a 2-bit counter over five back-to-back exceptions.
    for (int k = 0; k < 5; k++) begin
      exc_req2 = 1'b1;
      step();
      step();
      step();
      chk($sformatf("sat_ack%0d", k), {31'd0, exc_ack2}, 32'd1);
      exc_req2 = 1'b0;
      step();
      chk($sformatf("sat_busy%0d", k), {31'd0, busy2}, 32'd0);
      chk($sformatf("sat_cnt%0d", k), {30'd0, exc_count2}, {30'd0, exp6[k]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
